db_bound_monitor: RTL

Parametrised multi-channel frame tracker and response-bound checker for double-buffered memory cores running under the AQED harness. It sits between the `aqed_top` checker and one or more `memory_core` instances in DB mode (mode 3, tile_en). It generates per-channel write/read admission gates that enforce one-frame-in-flight. It watches the original transaction through a bound FSM and flags a sticky failure if the original's completion is not observed once the bounded read/write budget has elapsed.

---
 rtl/db_mon_pkg.sv | 21 ++
 rtl/db_chan_counter.sv | 55 +++++
 rtl/db_bound_monitor.sv | 122 ++++++++++++
 3 files changed

// File: rtl/db_mon_pkg.sv
// Shared types and defaults for the double-buffered memory frame/bound monitor.
package db_mon_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        TRACK = 2'd1,
        CHECK = 2'd2,
        HALT  = 2'd3
    } bound_state_t;

    localparam int unsigned DEF_DATA_W    = 16;
    localparam int unsigned DEF_CNT_W     = 16;
    localparam int unsigned DEF_NUM_CH    = 2;
    localparam int unsigned DEF_READ_MULT = 4;

    // Channel index width, never narrower than one bit.
    function automatic int unsigned CH_IDX_W(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/db_chan_counter.sv
// One channel's write/read frame counters, admission gates and frame-close pulse.
module db_chan_counter #(
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clk_en,
    input  logic             cfg_err,
    input  logic [CNT_W-1:0] depth,
    input  logic             wen,
    input  logic             ren,
    output logic             wen_ok,
    output logic             ren_ok,
    output logic             frame_done
);

    logic [CNT_W:0]   wcnt, rcnt, dep_x, wnext, rnext;
    logic [CNT_W+1:0] rlim;
    logic             wfire, rfire, wadv, radv, close;

    assign dep_x = {1'b0, depth};
    assign rlim  = {1'b0, wcnt} + {2'b0, depth};

    // Gates stay low while reset is held so they match their reset value.
    assign wen_ok = reset & ~cfg_err & (wcnt < dep_x);
    assign ren_ok = reset & ~cfg_err & (rcnt < dep_x) & ({1'b0, rcnt} < rlim);

    assign wfire = clk_en & wen;
    assign rfire = clk_en & ren;
    assign wadv  = wfire & wen_ok;
    assign radv  = rfire & ren_ok;
    assign wnext = wcnt + {{CNT_W{1'b0}}, wadv};
    assign rnext = rcnt + {{CNT_W{1'b0}}, radv};

    // Only admitted fires advance toward close; a rejected fire cannot close a frame.
    assign close = ~cfg_err & (wnext == dep_x) & (rnext == dep_x);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wcnt       <= '0;
            rcnt       <= '0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= close;
            if (close) begin
                wcnt <= '0;
                rcnt <= '0;
            end else begin
                wcnt <= (wfire & ~wen_ok) ? dep_x : wnext;
                rcnt <= (rfire & ~ren_ok) ? dep_x : rnext;
            end
        end
    end

endmodule

// File: rtl/db_bound_monitor.sv
// Multi-channel frame tracker plus bounded-response checker for the original transaction.
module db_bound_monitor
    import db_mon_pkg::*;
#(
    parameter int unsigned DATA_W    = DEF_DATA_W,
    parameter int unsigned CNT_W     = DEF_CNT_W,
    parameter int unsigned NUM_CH    = DEF_NUM_CH,
    parameter int unsigned READ_MULT = DEF_READ_MULT
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          clk_en,
    input  logic [CNT_W-1:0]              depth,
    input  logic [NUM_CH-1:0]             wen,
    input  logic [NUM_CH-1:0]             ren,
    input  logic [NUM_CH-1:0]             rvalid,
    input  logic                          orig_issued,
    input  logic [CH_IDX_W(NUM_CH)-1:0]   orig_ch,
    input  logic                          orig_done,
    output logic [NUM_CH-1:0]             wen_ok,
    output logic [NUM_CH-1:0]             ren_ok,
    output logic [NUM_CH-1:0]             frame_done,
    output logic [1:0]                    bound_state,
    output logic                          bound_pass,
    output logic                          bound_fail,
    output logic                          config_err
);

    localparam int unsigned IW   = CH_IDX_W(NUM_CH);
    localparam int unsigned RA_W = CNT_W + $clog2(READ_MULT) + 1;
    localparam int unsigned WA_W = CNT_W + 1;
    // An illegal parameter set is reported the same way as a zero depth.
    localparam bit PARAMS_OK = (DATA_W > 0) && (NUM_CH >= 1) && (NUM_CH <= 4) && (READ_MULT >= 1);

    bound_state_t    state, state_nx;
    logic [IW-1:0]   ch_q;
    logic [RA_W-1:0] r_after, r_target;
    logic [WA_W-1:0] w_after;
    logic            sel_r, sel_w, budget_met, done_seen;

    assign config_err = (depth == '0) | ~PARAMS_OK;

    for (genvar c = 0; c < NUM_CH; c++) begin : g_chan
        db_chan_counter #(.CNT_W(CNT_W)) u_chan (
            .clk        (clk),
            .reset      (reset),
            .clk_en     (clk_en),
            .cfg_err    (config_err),
            .depth      (depth),
            .wen        (wen[c]),
            .ren        (ren[c]),
            .wen_ok     (wen_ok[c]),
            .ren_ok     (ren_ok[c]),
            .frame_done (frame_done[c])
        );
    end

    always_comb begin
        sel_r = 1'b0;
        sel_w = 1'b0;
        for (int unsigned c = 0; c < NUM_CH; c++) begin
            if (ch_q == IW'(c)) begin
                sel_r = ren[c] & rvalid[c];
                sel_w = wen[c];
            end
        end
    end

    assign r_target   = RA_W'(READ_MULT) * RA_W'(depth);
    assign budget_met = (r_after >= r_target) & (w_after >= {1'b0, depth});

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (clk_en & orig_issued & ~config_err) state_nx = TRACK;
            TRACK:   if (clk_en & budget_met) state_nx = CHECK;
            CHECK:   if (clk_en) state_nx = HALT;
            HALT:    state_nx = HALT;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_nx;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ch_q       <= '0;
            r_after    <= '0;
            w_after    <= '0;
            bound_pass <= 1'b0;
            bound_fail <= 1'b0;
        end else if (clk_en) begin
            case (state)
                IDLE: if (orig_issued) begin
                    ch_q    <= orig_ch;
                    r_after <= '0;
                    w_after <= '0;
                end
                TRACK: begin
                    if (sel_r && r_after != '1) r_after <= r_after + RA_W'(1);
                    if (sel_w && w_after != '1) w_after <= w_after + WA_W'(1);
                end
                CHECK: begin
                    bound_pass <= done_seen;
                    bound_fail <= ~done_seen;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)         done_seen <= 1'b0;
        else if (orig_done) done_seen <= 1'b1;
    end

    assign bound_state = state;

endmodule
